fetch_seq: RTL

Fetch sequencer between the PC, a request/response instruction memory and the decode stage.
- Generates word-addressed fetch addresses (next PC = PC+1) and keeps one memory request outstanding.
- Buffers fetched instructions in a 2-entry queue with a valid/ready handshake to decode.
- Handles execute-stage redirects: flushes the queue and discards any stale in-flight response.

---
 rtl/fetch_seq_if.sv | 38 +++
 rtl/fetch_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus: instruction-memory request/response, execute redirect and
// the decode-side handoff, bundled so the sequencer and its environment share one port.
interface fetch_seq_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Transfers: a request moves on imem_req & imem_gnt; a response on imem_rvalid;
    // an instruction moves to decode on if_valid & id_ready. Once raised, if_valid
    // holds its entry until taken or flushed by redirect_valid.
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic          id_ready;
    logic [DW-1:0] ir_if;
    logic [AW-1:0] npc_if;
    logic [AW-1:0] pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, ir_if, npc_if, pc,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, ir_if, npc_if, pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: one outstanding imem request, 2-entry {ir, npc} queue to decode,
// redirect flush with stale-response drop. Optional counters under FETCH_PERF_EN.
module fetch_seq #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_seq_if.master bus,
    output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] q_ir  [2];
    logic [AW-1:0] q_npc [2];
    logic [1:0]    count;
    logic [1:0]    count_inc;
    logic [1:0]    wr_slot;
    logic          head_valid;
    logic          redirect;
    logic          pop;
    logic          push;
    logic          granted;
    logic          req;

    assign redirect   = bus.redirect_valid;
    assign head_valid = (count != 2'd0);
    // A pop coinciding with a redirect is void: the flush wins.
    assign pop        = head_valid & bus.id_ready & ~redirect;
    assign count_inc  = count + 2'd1 - {1'b0, pop};
    assign wr_slot    = count - {1'b0, pop};

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        granted  = 1'b0;
        req      = 1'b0;
        case (state)
            S_REQ: begin
                req = 1'b1;
                if (redirect) begin
                    state_nx = bus.imem_gnt ? S_DROP : S_REQ;
                end else if (bus.imem_gnt) begin
                    granted  = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_nx = bus.imem_rvalid ? S_REQ : S_DROP;
                end else if (bus.imem_rvalid) begin
                    push     = 1'b1;
                    state_nx = (count_inc < 2'd2) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || pop) state_nx = S_REQ;
            end
            S_DROP: begin
                // The stale response retires the outstanding request even if
                // another redirect lands in the same cycle.
                if (bus.imem_rvalid) state_nx = S_REQ;
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc_q     <= RESET_PC;
            req_addr <= '0;
            count    <= 2'd0;
            q_ir[0]  <= '0;
            q_ir[1]  <= '0;
            q_npc[0] <= '0;
            q_npc[1] <= '0;
        end else begin
            state <= state_nx;
            if (redirect)     pc_q <= bus.redirect_pc;
            else if (granted) pc_q <= pc_q + AW'(1);
            if (granted) req_addr <= pc_q;

            if (redirect) begin
                count <= 2'd0;
            end else begin
                if (pop) begin
                    q_ir[0]  <= q_ir[1];
                    q_npc[0] <= q_npc[1];
                end
                // Later assignment wins when the push lands in the slot just vacated.
                if (push) begin
                    q_ir[wr_slot[0]]  <= bus.imem_rdata;
                    q_npc[wr_slot[0]] <= req_addr + AW'(1);
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.if_valid  = head_valid;
    assign bus.ir_if     = head_valid ? q_ir[0]  : '0;
    assign bus.npc_if    = head_valid ? q_npc[0] : '0;
    assign dbg_state     = state;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)                           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.id_ready && !head_valid)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect)                      perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
